an_dec_decoder: RTL and testbench
=================================

Name: an_dec_decoder

Overview:
- Parametrised successor to the fixed A=1939 trade-off decoder.
- Decodes an AN-coded word, where the received word is W = A*N + e and e is 0, ±2^i, or ±2^i ± 2^j.
- Returns N, an error class and the signed error positions. Positions use the team's LUT encoding: ±(i+1), 0 = none.
- LUTs are replaced by on-the-fly 2^i mod A generation, and '/' by a sequential restoring divider. Any A and width are supported.
- Sits between the AN-coded arithmetic datapath and the consumer, behind valid/ready on both sides.

Parameters:
- A, 1939, code constant; odd, A < 2^A_BITS.
- W_BITS, 20, received word width.
- A_BITS, 11, residue width.
- N_BITS, 9, decoded data width.
- L_BITS, 5, position magnitude width; position ports are L_BITS+1 signed.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- in_valid, input, 1: in_word valid.
- in_ready, output, 1: high only in IDLE.
- in_word, input, W_BITS: received word.
- out_valid, output, 1: result valid; held until accepted.
- out_ready, input, 1: consumer accepts.
- out_data, output, N_BITS: decoded N.
- out_status, output, 2: 00 clean, 01 single corrected, 10 double corrected, 11 uncorrectable.
- out_err1, output, L_BITS+1 signed: first error position ±(i+1).
- out_err2, output, L_BITS+1 signed: second error position; 0 if none.

Behaviour:
- Reset (async) puts the FSM in IDLE. out_valid, out_data, out_status, out_err1 and out_err2 are all 0. in_ready = 1 once rst_n is high.
- Reset mid-operation aborts all work; there is no partial output.
- States: IDLE, DIV, CHK, SEC, DEC_O, DEC_I, FIX, OUT.
- IDLE: when in_valid && in_ready, latch in_word into a W_BITS+1 signed working register, then go to DIV.
- DIV: restoring division by A, one quotient bit per cycle, W_BITS cycles, producing Q and R = W mod A.
- CHK, after the first divide:
  - R == 0 gives status 00, data = Q[N_BITS-1:0], errs 0, then OUT.
  - Otherwise go to SEC with i = 0 and p = 1.
- CHK, after a FIX re-divide:
  - R must be 0; go to OUT with the pending status.
  - R != 0 gives status 11.
- SEC: one position per cycle; p_{i+1} = 2p mod A by compare-subtract.
  - R == p means e = +2^i, err1 = +(i+1).
  - Else R == A-p means e = -2^i, err1 = -(i+1).
  - On a match, the corrected word is W - e; go to FIX.
  - After i = W_BITS-1 with no match, go to DEC_O.
- DEC_O / DEC_I: nested scan over i < j < W_BITS.
  - Outer residue R1 = (R - s1*p_i) mod A, taken in A_BITS+1 signed and folded by +A if negative.
  - Inner loop compares R1 with q_j and A - q_j.
  - Scan order: i ascending; s1 = +1 before -1; j ascending; + before -. The first match wins.
  - On a match: err1 = s1(i+1), err2 = s2(j+1), corrected = W - s1*2^i - s2*2^j; go to FIX.
  - Exhaustion gives status 11.
- FIX: if the corrected word is < 0 or ≥ 2^W_BITS, status 11. Otherwise load it into the divider, return to DIV, and re-divide.
- Status 11 reports: out_data = Q of the original word, errs 0.
- OUT: out_valid = 1 with all outputs stable until out_valid && out_ready. On that edge go to IDLE; in_ready returns 1 the next cycle.
- Latency:
  - Clean word: out_valid high W_BITS+2 edges after the accept edge.
  - Single error at position i: W_BITS+2 + (i+1) + 1 + W_BITS+1 edges.
  - Double error: bounded by 2*W_BITS^2 additional cycles.
- Quotient bits above N_BITS are truncated.
- in_valid is ignored while not in IDLE.

Optional Feature:
- Macro AN_DEC_DEC_EN.
- Defined: DEC_O/DEC_I are present and double errors are corrected.
- Undefined: DEC_O/DEC_I are not synthesised. SEC exhaustion gives status 11 directly, and status 10 never occurs.

Test Plan (A=1939, W_BITS=20):
- in_word = 193900 -> status 00, data 100, err1 = err2 = 0; out_valid exactly 22 edges after accept.
- in_word = 193908 (+2^3) -> status 01, data 100, err1 +4, err2 0. in_word = 192876 (-2^10) -> status 01, data 100, err1 -11.
- in_word = 193646 (+2^1 - 2^8, R = 1685) with AN_DEC_DEC_EN -> status 10, data 100, err1 +2, err2 -9. Same word without the macro -> status 11, data 99.
- Backpressure: out_ready held 0 for 10 cycles -> out_valid and outputs stable, in_ready 0. On release, in_ready is 1 on the next cycle and a back-to-back word is accepted.
- rst_n pulsed low during SEC -> all outputs 0 immediately, in_ready 1 after release. The next word 1939*263 decodes clean to 263.
- in_word = 2^20 - 1 with residue forcing correction above the range -> status 11; no out-of-range corrected value is ever divided.

Source files
------------

// File: rtl/an_dec_decoder.sv
// an_dec_decoder: sequential AN-code decoder (restoring divider + residue scan).
// Define AN_DEC_DEC_EN to add the double-error scan states (DEC_O / DEC_I).
module an_dec_decoder #(
    parameter int A      = 1939,
    parameter int W_BITS = 20,
    parameter int A_BITS = 11,
    parameter int N_BITS = 9,
    parameter int L_BITS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W_BITS-1:0]      in_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_BITS-1:0]      out_data,
    output logic [1:0]             out_status,
    output logic signed [L_BITS:0] out_err1,
    output logic signed [L_BITS:0] out_err2
);
    localparam int CW = W_BITS + 2;
    localparam int IW = $clog2(W_BITS + 1);
    localparam logic [A_BITS-1:0] A_R = A_BITS'(A);
    localparam logic [IW-1:0] LAST = IW'(W_BITS - 1);

    typedef enum logic [2:0] {IDLE, DIV, CHK, SEC, DEC_O, DEC_I, FIX, OUT} state_t;
    state_t state;

    logic signed [W_BITS:0] word;
    logic signed [CW-1:0]   fixed, wext, pow_i;
    logic [W_BITS-1:0]      dividend;
    logic [A_BITS-1:0]      rem, rem_next, p;
    logic [A_BITS:0]        trial;
    logic                   q_bit, sec_pos, sec_neg, div_init, redo;
    logic [N_BITS-1:0]      quo, q_orig;
    logic [IW-1:0]          cnt, i;
    logic [1:0]             status_pend;
    logic signed [L_BITS:0] err1_pend, err2_pend;

    function automatic logic [A_BITS-1:0] dbl_mod(input logic [A_BITS-1:0] x);
        logic [A_BITS:0] d;
        d = {x, 1'b0};
        if (d >= {1'b0, A_R}) d = d - {1'b0, A_R};
        return d[A_BITS-1:0];
    endfunction

    // Position encoding: +/-(k+1), sign chosen by neg.
    function automatic logic signed [L_BITS:0] pos(input logic [IW-1:0] k, input logic neg);
        logic signed [L_BITS:0] v;
        v = $signed((L_BITS+1)'(k) + (L_BITS+1)'(1));
        return neg ? -v : v;
    endfunction

    always_comb begin
        trial    = {rem, dividend[W_BITS-1]};
        q_bit    = (trial >= {1'b0, A_R});
        rem_next = q_bit ? A_BITS'(trial - {1'b0, A_R}) : A_BITS'(trial);
    end

    assign wext     = {word[W_BITS], word};
    assign pow_i    = CW'(1) << i;
    assign sec_pos  = (rem == p);
    assign sec_neg  = (rem == A_R - p);
    assign in_ready = (state == IDLE);

`ifdef AN_DEC_DEC_EN
    logic [IW-1:0]          j;
    logic [A_BITS-1:0]      q, r1;
    logic                   s1_neg, dec_pos, dec_neg;
    logic signed [A_BITS:0] r1_raw;
    logic signed [CW-1:0]   pow_j, term_i, term_j;

    // R - s1*p folded into [0, A); s1 = -1 uses R - (A - p) to stay in range.
    always_comb begin
        r1_raw = $signed({1'b0, rem}) - $signed({1'b0, s1_neg ? A_R - p : p});
        if (r1_raw < 0) r1_raw = r1_raw + $signed({1'b0, A_R});
    end

    assign dec_pos = (r1 == q);
    assign dec_neg = (r1 == A_R - q);
    assign pow_j   = CW'(1) << j;
    assign term_i  = s1_neg ? -pow_i : pow_i;
    assign term_j  = dec_pos ? pow_j : -pow_j;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_status  <= '0;
            out_err1    <= '0;
            out_err2    <= '0;
            word        <= '0;
            fixed       <= '0;
            dividend    <= '0;
            rem         <= '0;
            quo         <= '0;
            q_orig      <= '0;
            cnt         <= '0;
            i           <= '0;
            p           <= '0;
            div_init    <= 1'b0;
            redo        <= 1'b0;
            status_pend <= '0;
            err1_pend   <= '0;
            err2_pend   <= '0;
`ifdef AN_DEC_DEC_EN
            j           <= '0;
            q           <= '0;
            r1          <= '0;
            s1_neg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    word     <= $signed({1'b0, in_word});
                    div_init <= 1'b1;
                    redo     <= 1'b0;
                    state    <= DIV;
                end
                DIV: begin
                    if (div_init) begin
                        dividend <= word[W_BITS-1:0];
                        rem      <= '0;
                        cnt      <= '0;
                        div_init <= 1'b0;
                    end else begin
                        dividend <= {dividend[W_BITS-2:0], 1'b0};
                        quo      <= {quo[N_BITS-2:0], q_bit};
                        rem      <= rem_next;
                        cnt      <= cnt + IW'(1);
                        if (cnt == LAST) state <= CHK;
                    end
                end
                CHK: begin
                    if (rem == '0) begin
                        out_data   <= quo;
                        out_status <= redo ? status_pend : 2'b00;
                        out_err1   <= redo ? err1_pend : '0;
                        out_err2   <= redo ? err2_pend : '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else if (!redo) begin
                        q_orig <= quo;
                        i      <= '0;
                        p      <= A_BITS'(1);
                        state  <= SEC;
                    end else begin
                        out_data   <= q_orig;
                        out_status <= 2'b11;
                        out_err1   <= '0;
                        out_err2   <= '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end
                end
                SEC: begin
                    if (sec_pos || sec_neg) begin
                        err1_pend   <= pos(i, !sec_pos);
                        err2_pend   <= '0;
                        status_pend <= 2'b01;
                        fixed       <= sec_pos ? wext - pow_i : wext + pow_i;
                        state       <= FIX;
                    end else if (i == LAST) begin
`ifdef AN_DEC_DEC_EN
                        i      <= '0;
                        p      <= A_BITS'(1);
                        s1_neg <= 1'b0;
                        state  <= DEC_O;
`else
                        out_data   <= q_orig;
                        out_status <= 2'b11;
                        out_err1   <= '0;
                        out_err2   <= '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
`endif
                    end else begin
                        i <= i + IW'(1);
                        p <= dbl_mod(p);
                    end
                end
`ifdef AN_DEC_DEC_EN
                DEC_O: begin
                    if (i == LAST) begin
                        out_data   <= q_orig;
                        out_status <= 2'b11;
                        out_err1   <= '0;
                        out_err2   <= '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        r1    <= r1_raw[A_BITS-1:0];
                        q     <= dbl_mod(p);
                        j     <= i + IW'(1);
                        state <= DEC_I;
                    end
                end
                DEC_I: begin
                    if (dec_pos || dec_neg) begin
                        err1_pend   <= pos(i, s1_neg);
                        err2_pend   <= pos(j, !dec_pos);
                        status_pend <= 2'b10;
                        fixed       <= wext - term_i - term_j;
                        state       <= FIX;
                    end else if (j == LAST) begin
                        if (!s1_neg) begin
                            s1_neg <= 1'b1;
                        end else begin
                            s1_neg <= 1'b0;
                            i      <= i + IW'(1);
                            p      <= dbl_mod(p);
                        end
                        state <= DEC_O;
                    end else begin
                        j <= j + IW'(1);
                        q <= dbl_mod(q);
                    end
                end
`endif
                // Corrected words outside [0, 2^W_BITS) never reach the divider.
                FIX: begin
                    if (fixed[CW-1:W_BITS] != '0) begin
                        out_data   <= q_orig;
                        out_status <= 2'b11;
                        out_err1   <= '0;
                        out_err2   <= '0;
                        out_valid  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        dividend <= fixed[W_BITS-1:0];
                        rem      <= '0;
                        cnt      <= '0;
                        div_init <= 1'b0;
                        redo     <= 1'b1;
                        state    <= DIV;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_an_dec_decoder.sv
// Table-driven bench for an_dec_decoder (A=1939, W_BITS=20) plus backpressure and reset sequences.
module tb_an_dec_decoder;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [19:0]       in_word;
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        out_data;
    logic [1:0]        out_status;
    logic signed [5:0] out_err1;
    logic signed [5:0] out_err2;

    int total = 0;
    int passed = 0;

    an_dec_decoder #(.A(1939), .W_BITS(20), .A_BITS(11), .N_BITS(9), .L_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_status(out_status), .out_err1(out_err1), .out_err2(out_err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] word;
        logic [1:0]  status;
        logic [8:0]  data;
        int          err1;
        int          err2;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [19:0] w);
        @(negedge clk);
        check("send.in_ready", in_ready, 1);
        in_word  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic stable;
        logic [8:0] d0;
        logic [1:0] s0;
        logic signed [5:0] e10, e20;

        vecs[0]  = '{20'd193900,  2'b00, 9'd100, 0,   0,  22};
        vecs[1]  = '{20'd193908,  2'b01, 9'd100, 4,   0,  48};
        vecs[2]  = '{20'd192876,  2'b01, 9'd100, -11, 0,  55};
        vecs[3]  = '{20'd193899,  2'b01, 9'd100, -1,  0,  45};
        vecs[4]  = '{20'd718188,  2'b01, 9'd100, 20,  0,  64};
`ifdef AN_DEC_DEC_EN
        vecs[5]  = '{20'd193646,  2'b10, 9'd100, 2,   -9, -1};
`else
        vecs[5]  = '{20'd193646,  2'b11, 9'd99,  0,   0,  -1};
`endif
        vecs[6]  = '{20'd1047975, 2'b11, 9'd28,  0,   0,  -1};
        vecs[7]  = '{20'd1048575, 2'b11, 9'd28,  0,   0,  -1};
        vecs[8]  = '{20'd0,       2'b00, 9'd0,   0,   0,  22};
        vecs[9]  = '{20'd990829,  2'b00, 9'd511, 0,   0,  22};
        vecs[10] = '{20'd992768,  2'b00, 9'd0,   0,   0,  22};
        vecs[11] = '{20'd509957,  2'b00, 9'd263, 0,   0,  22};

        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.out_data", out_data, 0);
        check("rst.out_status", out_status, 0);
        check("rst.out_err1", out_err1, 0);
        check("rst.out_err2", out_err2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", in_ready, 1);

        for (int k = 0; k < 12; k++) begin
            send(vecs[k].word);
            wait_out(lat);
            check($sformatf("v%0d.done", k), out_valid, 1);
            check($sformatf("v%0d.status", k), out_status, vecs[k].status);
            check($sformatf("v%0d.data", k), out_data, vecs[k].data);
            check($sformatf("v%0d.err1", k), out_err1, vecs[k].err1);
            check($sformatf("v%0d.err2", k), out_err2, vecs[k].err2);
            if (vecs[k].lat >= 0) check($sformatf("v%0d.latency", k), lat, vecs[k].lat);
            accept();
            check($sformatf("v%0d.valid_drop", k), out_valid, 0);
        end

        // Backpressure: hold the result for 10 cycles, then a back-to-back word.
        send(20'd193908);
        wait_out(lat);
        check("bp.done", out_valid, 1);
        d0 = out_data; s0 = out_status; e10 = out_err1; e20 = out_err2;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out_data != d0 || out_status != s0 ||
                out_err1 != e10 || out_err2 != e20) stable = 1'b0;
        end
        check("bp.stable", stable, 1);
        check("bp.status", s0, 2'b01);
        check("bp.err1", e10, 4);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_word   = 20'd193900;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp.in_ready_next", in_ready, 1);
        check("bp.valid_drop", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.busy", in_ready, 0);
        wait_out(lat);
        check("bp2.latency", lat, 22);
        check("bp2.status", out_status, 2'b00);
        check("bp2.data", out_data, 100);
        accept();

        // Reset while scanning single-error positions.
        send(20'd193908);
        repeat (23) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", out_valid, 0);
        check("mid.out_data", out_data, 0);
        check("mid.out_status", out_status, 0);
        check("mid.out_err1", out_err1, 0);
        check("mid.out_err2", out_err2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid.in_ready", in_ready, 1);
        send(20'd509957);
        wait_out(lat);
        check("mid2.latency", lat, 22);
        check("mid2.status", out_status, 2'b00);
        check("mid2.data", out_data, 263);
        check("mid2.err1", out_err1, 0);
        accept();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
